tile_map_renderer: RTL and testbench

- Initiator side of the tile sprite-pattern memory (the block that drives select/x/y and consumes the 2-bit pixel).
- Converts the VGA scan position plus a frame-synchronous scroll offset into world coordinates.
- Fetches the tile index from the external tile-map RAM, then fetches the pattern pixel and maps it through a 4-entry palette to 12-bit RGB.
- Sits between the VGA timing generator and the DAC output register; delays sync and blank sidebands to stay aligned with colour.

---
 rtl/tile_map_renderer_pkg.sv | 25 ++
 rtl/tile_map_renderer_palette.sv | 31 +++
 rtl/tile_map_renderer.sv | 166 ++++++++++++++++
 tb/tb_tile_map_renderer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_renderer_pkg.sv
// Shared constants and types for the tile-map renderer.
// Palette defaults, widths and the pixel pipeline latency.
package tile_map_renderer_pkg;

  localparam int RGB_W    = 12;
  localparam int SPR_W    = 6;
  localparam int TILE_PX  = 16;
  localparam int TILE_LG  = 4;
  localparam int PIPE_LAT = 4;

  localparam logic [RGB_W-1:0] PAL0 = 12'h000;
  localparam logic [RGB_W-1:0] PAL1 = 12'h0A0;
  localparam logic [RGB_W-1:0] PAL2 = 12'h850;
  localparam logic [RGB_W-1:0] PAL3 = 12'hFFF;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sband_t;

  localparam sband_t SB_ZERO = '{hs: 1'b0, vs: 1'b0, von: 1'b0};
  localparam sband_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

endpackage

// File: rtl/tile_map_renderer_palette.sv
// Four-entry colour palette: one write port, one async read.
// Resets to the package default colours.
module render_palette
  import tile_map_renderer_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [1:0]       wr_idx_i,
  input  logic [RGB_W-1:0] wr_data_i,
  input  logic [1:0]       rd_idx_i,
  output logic [RGB_W-1:0] rd_data_o
);

  logic [3:0][RGB_W-1:0] pal_q;

  // Palette storage; a write lands at the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pal_q[0] <= PAL0;
      pal_q[1] <= PAL1;
      pal_q[2] <= PAL2;
      pal_q[3] <= PAL3;
    end else if (we_i) begin
      pal_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = pal_q[rd_idx_i];

endmodule

// File: rtl/tile_map_renderer.sv
// Scrolling tile-map pixel pipeline: scan position to RGB.
// Four clocks of latency; sync/blank delayed to match colour.
module tile_map_renderer
  import tile_map_renderer_pkg::*;
#(
  parameter int TILE_COLS = 64,
  parameter int TILE_ROWS = 32,
  parameter int COL_W     = 6,
  parameter int ROW_W     = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [9:0]               pix_x,
  input  logic [9:0]               pix_y,
  input  logic                     video_on,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     frame_start,
  input  logic                     scroll_valid,
  output logic                     scroll_ready,
  input  logic [COL_W+TILE_LG-1:0] scroll_x_in,
  input  logic [ROW_W+TILE_LG-1:0] scroll_y_in,
  output logic [COL_W+ROW_W-1:0]   tmap_addr,
  input  logic [SPR_W-1:0]         tmap_q,
  output logic [SPR_W-1:0]         spr_select,
  output logic [TILE_LG-1:0]       spr_x,
  output logic [TILE_LG-1:0]       spr_y,
  input  logic [1:0]               spr_pixel,
  input  logic                     pal_we,
  input  logic [1:0]               pal_idx,
  input  logic [RGB_W-1:0]         pal_data,
  output logic [RGB_W-1:0]         rgb,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     video_on_out
);

  localparam int WX_W = $clog2(TILE_COLS) + TILE_LG;
  localparam int WY_W = $clog2(TILE_ROWS) + TILE_LG;

  logic [WX_W-1:0] scx_q, scx_d;
  logic [WY_W-1:0] scy_q, scy_d;
  logic [WX_W-1:0] pdx_q, pdx_d;
  logic [WY_W-1:0] pdy_q, pdy_d;
  logic            pfull_q, pfull_d;
  logic            apply;
  logic            take;

  logic [WX_W-1:0] wx_d;
  logic [WY_W-1:0] wy_d;
  logic [WX_W-1:0] wx1_q;
  logic [WY_W-1:0] wy1_q;
  sband_t          sb_d;
  sband_t          sb1_q;

  logic [TILE_LG-1:0] fx2_q;
  logic [TILE_LG-1:0] fy2_q;
  sband_t             sb2_q;
  sband_t             sb3_q;

  logic [RGB_W-1:0] pal_rd;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  sband_t           sbo_q;

  assign scroll_ready = !pfull_q;
  assign apply = frame_start && pfull_q;
  assign take  = scroll_valid && !pfull_q;

  // Pending slot fills on handshake; frame_start promotes it.
  always_comb begin
    scx_d   = scx_q;
    scy_d   = scy_q;
    pdx_d   = pdx_q;
    pdy_d   = pdy_q;
    pfull_d = pfull_q;
    unique case (1'b1)
      apply: begin
        scx_d   = pdx_q;
        scy_d   = pdy_q;
        pfull_d = 1'b0;
      end
      take: begin
        pdx_d   = scroll_x_in;
        pdy_d   = scroll_y_in;
        pfull_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Scroll state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scx_q   <= '0;
      scy_q   <= '0;
      pdx_q   <= '0;
      pdy_q   <= '0;
      pfull_q <= 1'b0;
    end else begin
      scx_q   <= scx_d;
      scy_q   <= scy_d;
      pdx_q   <= pdx_d;
      pdy_q   <= pdy_d;
      pfull_q <= pfull_d;
    end
  end

  assign wx_d = WX_W'(pix_x) + scx_q;
  assign wy_d = WY_W'(pix_y) + scy_q;
  assign sb_d = '{hs: hsync_in, vs: vsync_in, von: video_on};

  // Stages 1-3: world coords, in-tile coords, sideband delay.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wx1_q <= '0;
      wy1_q <= '0;
      sb1_q <= SB_ZERO;
      fx2_q <= '0;
      fy2_q <= '0;
      sb2_q <= SB_ZERO;
      sb3_q <= SB_ZERO;
    end else begin
      wx1_q <= wx_d;
      wy1_q <= wy_d;
      sb1_q <= sb_d;
      fx2_q <= wx1_q[TILE_LG-1:0];
      fy2_q <= wy1_q[TILE_LG-1:0];
      sb2_q <= sb1_q;
      sb3_q <= sb2_q;
    end
  end

  assign tmap_addr  = {wy1_q[WY_W-1:TILE_LG], wx1_q[WX_W-1:TILE_LG]};
  assign spr_select = tmap_q;
  assign spr_x      = fx2_q;
  assign spr_y      = fy2_q;

  render_palette u_pal (
    .clock     (clock),
    .reset_n   (reset_n),
    .we_i      (pal_we),
    .wr_idx_i  (pal_idx),
    .wr_data_i (pal_data),
    .rd_idx_i  (spr_pixel),
    .rd_data_o (pal_rd)
  );

  assign rgb_d = sb3_q.von ? pal_rd : '0;

  // Output register: colour plus aligned sidebands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      sbo_q <= SB_IDLE;
    end else begin
      rgb_q <= rgb_d;
      sbo_q <= sb3_q;
    end
  end

  assign rgb          = rgb_q;
  assign hsync_out    = sbo_q.hs;
  assign vsync_out    = sbo_q.vs;
  assign video_on_out = sbo_q.von;

endmodule

// File: tb/tb_tile_map_renderer.sv
// Bench for tile_map_renderer: directed steps then random
// traffic, all checked against a world-coordinate model.
module tb_tile_map_renderer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  pix_x, pix_y;
  logic        video_on, hsync_in, vsync_in, frame_start;
  logic        scroll_valid, scroll_ready;
  logic [9:0]  scroll_x_in;
  logic [8:0]  scroll_y_in;
  logic [10:0] tmap_addr;
  logic [5:0]  tmap_q;
  logic [5:0]  spr_select;
  logic [3:0]  spr_x, spr_y;
  logic [1:0]  spr_pixel;
  logic        pal_we;
  logic [1:0]  pal_idx;
  logic [11:0] pal_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, video_on_out;

  tile_map_renderer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .frame_start  (frame_start),
    .scroll_valid (scroll_valid),
    .scroll_ready (scroll_ready),
    .scroll_x_in  (scroll_x_in),
    .scroll_y_in  (scroll_y_in),
    .tmap_addr    (tmap_addr),
    .tmap_q       (tmap_q),
    .spr_select   (spr_select),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_pixel    (spr_pixel),
    .pal_we       (pal_we),
    .pal_idx      (pal_idx),
    .pal_data     (pal_data),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .video_on_out (video_on_out)
  );

  always #5 clock = ~clock;

  logic [5:0] tmem [2048];
  int pat_mode;

  function automatic int pat(int sel, int x, int y);
    if (pat_mode == 0) return x % 4;
    return (sel * 3 + x + 2 * y) % 4;
  endfunction

  always @(posedge clock) begin
    tmap_q    <= tmem[tmap_addr];
    spr_pixel <= 2'(pat(int'(spr_select), int'(spr_x), int'(spr_y)));
  end

  typedef struct {
    int addr;
    int fx;
    int fy;
    int pix;
    bit von;
    bit hs;
    bit vs;
  } ent_t;

  ent_t q[$];
  int   m_sx, m_sy, m_px, m_py;
  bit   m_full;
  int   mpal[4];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp1[4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sx = 0; m_sy = 0; m_px = 0; m_py = 0; m_full = 0;
    mpal[0] = 'h000; mpal[1] = 'h0A0;
    mpal[2] = 'h850; mpal[3] = 'hFFF;
  endtask

  task automatic pix(input int x, input int y, input bit von);
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_on = von;
  endtask

  // One pixel clock: predict, clock, compare, retire.
  task automatic tick();
    ent_t e;
    int wx, wy, tile;
    chk("ready", {31'd0, scroll_ready}, {31'd0, !m_full});
    wx = (int'(pix_x) + m_sx) % 1024;
    wy = (int'(pix_y) + m_sy) % 512;
    e.addr = (wy / 16) * 64 + wx / 16;
    tile = int'(tmem[e.addr]);
    e.fx = wx % 16;
    e.fy = wy % 16;
    e.pix = pat(tile, e.fx, e.fy);
    e.von = video_on;
    e.hs = hsync_in;
    e.vs = vsync_in;
    q.push_back(e);
    if (frame_start && m_full) begin
      m_sx = m_px; m_sy = m_py; m_full = 0;
    end else if (scroll_valid && !m_full) begin
      m_px = int'(scroll_x_in); m_py = int'(scroll_y_in); m_full = 1;
    end
    @(posedge clock);
    #1;
    chk("tmap_addr", 32'(tmap_addr), q[$].addr);
    if (q.size() >= 2) begin
      chk("spr_x", 32'(spr_x), q[$-1].fx);
      chk("spr_y", 32'(spr_y), q[$-1].fy);
    end
    if (q.size() == 4) begin
      e = q.pop_front();
      chk("rgb", 32'(rgb), e.von ? mpal[e.pix] : 0);
      chk("hsync_out", {31'd0, hsync_out}, {31'd0, e.hs});
      chk("vsync_out", {31'd0, vsync_out}, {31'd0, e.vs});
      chk("video_on_out", {31'd0, video_on_out}, {31'd0, e.von});
    end else begin
      chk("refill_rgb", 32'(rgb), 0);
      chk("refill_von", {31'd0, video_on_out}, 0);
    end
    if (pal_we) mpal[pal_idx] = int'(pal_data);
  endtask

  // Async reset asserted mid-cycle, released mid-cycle.
  task automatic do_reset(input int hold);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hs", {31'd0, hsync_out}, 1);
    chk("rst_vs", {31'd0, vsync_out}, 1);
    chk("rst_von", {31'd0, video_on_out}, 0);
    chk("rst_ready", {31'd0, scroll_ready}, 1);
    chk("rst_addr", 32'(tmap_addr), 0);
    chk("rst_sprx", 32'(spr_x), 0);
    chk("rst_spry", 32'(spr_y), 0);
    repeat (hold) @(posedge clock);
    #3 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit acc;
    reset_n = 1'b1;
    pix(0, 0, 0);
    hsync_in = 1; vsync_in = 1; frame_start = 0;
    scroll_valid = 0; scroll_x_in = 0; scroll_y_in = 0;
    pal_we = 0; pal_idx = 0; pal_data = 0;
    pat_mode = 0;
    foreach (tmem[i]) tmem[i] = 6'd1;
    exp1[0] = 'h000; exp1[1] = 'h0A0;
    exp1[2] = 'h850; exp1[3] = 'hFFF;
    do_reset(2);

    // T1: default palette, 4-clock latency, sync delay
    for (int k = 0; k < 8; k++) begin
      pix(k, 0, k < 4);
      hsync_in = (k != 2);
      tick();
      if (k >= 3 && k <= 6) chk("t1_rgb", 32'(rgb), exp1[k-3]);
    end
    hsync_in = 1;

    // T2: scroll offered mid-frame, applied at frame_start
    scroll_valid = 1; scroll_x_in = 10'd1008; scroll_y_in = 9'd500;
    pix(100, 0, 1);
    tick();
    scroll_valid = 0;
    chk("t2_ready_low", {31'd0, scroll_ready}, 0);
    pix(20, 20, 1);
    tick();
    chk("t2_unchanged", 32'(tmap_addr), 65);
    frame_start = 1;
    pix(0, 480, 0);
    tick();
    frame_start = 0;
    chk("t2_ready_back", {31'd0, scroll_ready}, 1);
    pix(20, 20, 1);
    tick();
    chk("t2_addr", 32'(tmap_addr), 0);
    pix(21, 20, 1);
    tick();
    chk("t2_sprx", 32'(spr_x), 4);
    chk("t2_spry", 32'(spr_y), 8);
    repeat (4) tick();

    // T3: offer and frame_start together with slot empty
    scroll_valid = 1; scroll_x_in = 10'd16; scroll_y_in = 9'd32;
    frame_start = 1;
    tick();
    scroll_valid = 0; frame_start = 0;
    pix(0, 0, 1);
    tick();
    chk("t3_old_addr", 32'(tmap_addr), 2047);
    chk("t3_ready_low", {31'd0, scroll_ready}, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("t3_ready_back", {31'd0, scroll_ready}, 1);
    tick();
    chk("t3_new_addr", 32'(tmap_addr), 129);

    // T4: valid held while slot is full
    scroll_valid = 1; scroll_x_in = 10'd32; scroll_y_in = 9'd0;
    tick();
    scroll_x_in = 10'd48; scroll_y_in = 9'd16;
    repeat (3) begin
      tick();
      chk("t4_ready_low", {31'd0, scroll_ready}, 0);
    end
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("t4_ready_free", {31'd0, scroll_ready}, 1);
    tick();
    scroll_valid = 0;
    chk("t4_refilled", {31'd0, scroll_ready}, 0);
    tick();
    chk("t4_first_addr", 32'(tmap_addr), 2);
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
    chk("t4_second_addr", 32'(tmap_addr), 67);

    // T5: palette write during active display
    for (int k = 0; k < 20; k++) begin
      pix(k, 0, k < 12);
      pal_we = (k == 6); pal_idx = 2'd2; pal_data = 12'hF00;
      tick();
      if (k == 5) chk("t5_before", 32'(rgb), 'h850);
      if (k == 13) chk("t5_after", 32'(rgb), 'hF00);
      if (k == 17) chk("t5_blank", 32'(rgb), 0);
    end
    pal_we = 0;

    // T6: reset mid-line restores scroll and palette
    repeat (3) begin
      pix(5, 3, 1);
      tick();
    end
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      pix(k, 5, k < 4);
      tick();
      if (k >= 3 && k <= 6) chk("t6_rgb", 32'(rgb), exp1[k-3]);
    end

    // Random traffic with a random map and pattern
    foreach (tmem[i]) tmem[i] = 6'($urandom);
    pat_mode = 1;
    do_reset(1);
    acc = 0;
    for (int n = 0; n < 1500; n++) begin
      pix($urandom_range(0, 799), $urandom_range(0, 524),
          1'($urandom_range(0, 1)));
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      if (!scroll_valid || acc) begin
        scroll_valid = ($urandom_range(0, 2) == 0);
        scroll_x_in = 10'($urandom);
        scroll_y_in = 9'($urandom);
      end
      pal_we = ($urandom_range(0, 9) == 0);
      pal_idx = 2'($urandom);
      pal_data = 12'($urandom);
      acc = scroll_valid && scroll_ready;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
